// File: rtl/uart_core_param_pkg.sv
// Shared definitions for the parametrised UART core.
//  - parity mode and error-bit index constants
//  - TX/RX state encodings
//  - baud divisor and parity helpers used at elaboration and run time
package uart_core_param_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Bit positions inside rx_error = {overrun, parity_err, framing_err}
   localparam int ERR_FRAMING = 0;
   localparam int ERR_PARITY  = 1;
   localparam int ERR_OVERRUN = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   // Rounded clocks-per-oversample-tick; zero signals an unusable setting
   function automatic int baud_div(input longint clk_hz, input longint baud, input longint oversample);
      longint denom;
      denom = baud * oversample;
      if (denom <= 0) return 0;
      return int'((clk_hz + denom / 2) / denom);
   endfunction

   // Even parity is the XOR of the data, odd parity its inverse
   function automatic logic parity_bit(input logic data_xor, input int mode);
      return (mode == PARITY_ODD) ? ~data_xor : data_xor;
   endfunction

endpackage

// File: rtl/uart_core_param_if.sv
// Byte-stream handshake bundle between fabric logic and the UART core.
//  tx_data/tx_valid/tx_ready : word stream into the transmitter
//  rx_data/rx_valid/rx_ready : word stream out of the receiver
//  rx_error                  : {overrun, parity_err, framing_err}, qualified by rx_valid
// master = fabric side, slave = UART core side.
interface uart_core_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic [2:0]           rx_error;

   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, rx_data, rx_valid, rx_error
   );

   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, rx_data, rx_valid, rx_error
   );
endinterface

// File: rtl/uart_core_param_baud_tick.sv
// Free-running divider producing the oversample tick shared by TX and RX.
//  clk  in  system clock
//  rst  in  asynchronous active-high reset
//  tick out one-cycle pulse every DIV clocks (when the counter sits at DIV-1)
module uart_core_param_baud_tick #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   // Wrap at DIV-1 so the tick period is exactly DIV clocks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);
endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART core with oversampled, majority-voting receiver.
//  system_clk in   single clock for all logic
//  reset      in   asynchronous, active-high
//  bus        slave handshake bundle (tx_data/tx_valid/tx_ready, rx_data/rx_valid/rx_ready/rx_error)
//  tx         out  serial out, idle high
//  tx_busy    out  frame in progress
//  rx         in   serial in, asynchronous to system_clk
module uart_core_param
   import uart_core_param_pkg::*;
#(
   parameter int SYSTEM_CLOCK  = 100000000,
   parameter int UART_BAUDRATE = 115200,
   parameter int OVERSAMPLE    = 16,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1
) (
   input  logic        system_clk,
   input  logic        reset,
   uart_core_param_if.slave bus,
   output logic        tx,
   output logic        tx_busy,
   input  logic        rx
);
   localparam int DIV = baud_div(longint'(SYSTEM_CLOCK), longint'(UART_BAUDRATE), longint'(OVERSAMPLE));

   generate
      if (DIV < 1) begin : g_bad_div
         $error("uart_core_param: baud divisor rounds below 1");
      end
      if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
         $error("uart_core_param: OVERSAMPLE must be even and at least 8");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
         $error("uart_core_param: DATA_BITS must be 5..9");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
         $error("uart_core_param: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
         $error("uart_core_param: STOP_BITS must be 1 or 2");
      end
   endgenerate

   localparam int            CW        = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] OS_LAST   = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] MID_LO    = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] MID       = CW'(OVERSAMPLE / 2);
   localparam logic [CW-1:0] MID_HI    = CW'(OVERSAMPLE / 2 + 1);
   localparam int            BW        = $clog2(DATA_BITS);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic          HAS_PAR   = (PARITY != PARITY_NONE);
   localparam logic          TWO_STOP  = (STOP_BITS == 2);

   logic tick;

   uart_core_param_baud_tick #(.DIV(DIV)) u_tick (
      .clk  (system_clk),
      .rst  (reset),
      .tick (tick)
   );

   // ---------------------------------------------------------------- TX
   tx_state_t            tx_state;
   logic [DATA_BITS-1:0] tx_shift;
   logic                 tx_par;
   logic [CW-1:0]        tx_ticks;
   logic [BW-1:0]        tx_bit;
   logic                 tx_second_stop;

   // Transmitter: the start bit is driven as soon as a word is accepted and
   // every bit then lasts OVERSAMPLE ticks; tx itself is the registered line.
   always_ff @(posedge system_clk or posedge reset) begin
      if (reset) begin
         tx_state       <= TX_IDLE;
         tx             <= 1'b1;
         tx_shift       <= '0;
         tx_par         <= 1'b0;
         tx_ticks       <= '0;
         tx_bit         <= '0;
         tx_second_stop <= 1'b0;
      end else if (tx_state == TX_IDLE) begin
         if (bus.tx_valid) begin
            tx_shift       <= bus.tx_data;
            tx_par         <= parity_bit(^bus.tx_data, PARITY);
            tx_ticks       <= '0;
            tx_bit         <= '0;
            tx_second_stop <= 1'b0;
            tx             <= 1'b0;
            tx_state       <= TX_START;
         end
      end else if (tick) begin
         if (tx_ticks != OS_LAST) begin
            tx_ticks <= tx_ticks + 1'b1;
         end else begin
            tx_ticks <= '0;
            case (tx_state)
               TX_START: begin
                  tx_state <= TX_DATA;
                  tx       <= tx_shift[0];
               end
               TX_DATA: begin
                  if (tx_bit == DATA_LAST) begin
                     if (HAS_PAR) begin
                        tx_state <= TX_PARITY;
                        tx       <= tx_par;
                     end else begin
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
                     end
                  end else begin
                     tx_bit   <= tx_bit + 1'b1;
                     tx_shift <= tx_shift >> 1;
                     tx       <= tx_shift[1];
                  end
               end
               TX_PARITY: begin
                  tx_state <= TX_STOP;
                  tx       <= 1'b1;
               end
               TX_STOP: begin
                  if (!TWO_STOP || tx_second_stop) begin
                     tx_state <= TX_IDLE;
                  end else begin
                     tx_second_stop <= 1'b1;
                  end
               end
               default: begin
                  tx_state <= TX_IDLE;
                  tx       <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.tx_ready = (tx_state == TX_IDLE);
   assign tx_busy      = (tx_state != TX_IDLE);

   // ---------------------------------------------------------------- RX
   logic                 rx_meta;
   logic                 rx_sync;
   rx_state_t            rx_state;
   logic [CW-1:0]        rx_ticks;
   logic [BW-1:0]        rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_par_err;
   logic                 rx_armed;
   logic [1:0]           rx_samples;
   logic                 rx_vote;
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q;
   logic [2:0]           rx_error_q;

   // Two-flop synchroniser; idles high so reset does not look like a start bit
   always_ff @(posedge system_clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // Third sample is the live synchronised value at the deciding tick
   assign rx_vote = (rx_samples[0] & rx_samples[1]) |
                    (rx_samples[0] & rx_sync) |
                    (rx_samples[1] & rx_sync);

   // Receiver: each bit is decided by a 3-sample vote around mid-bit. The
   // frame ends at the mid-stop decision so the FSM re-arms early; after a
   // framing error rx_armed blocks re-arming until the line is seen high.
   always_ff @(posedge system_clk or posedge reset) begin
      if (reset) begin
         rx_state   <= RX_IDLE;
         rx_ticks   <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_par_err <= 1'b0;
         rx_armed   <= 1'b1;
         rx_samples <= 2'b11;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_error_q <= '0;
      end else begin
         if (rx_valid_q && bus.rx_ready) begin
            rx_valid_q <= 1'b0;
         end
         if (rx_state == RX_IDLE) begin
            if (rx_sync) begin
               rx_armed <= 1'b1;
            end else if (tick && rx_armed) begin
               rx_state   <= RX_START;
               rx_ticks   <= '0;
               rx_bit     <= '0;
               rx_par_err <= 1'b0;
            end
         end else if (tick) begin
            if (rx_ticks == MID_LO) rx_samples[0] <= rx_sync;
            if (rx_ticks == MID)    rx_samples[1] <= rx_sync;
            rx_ticks <= (rx_ticks == OS_LAST) ? '0 : rx_ticks + 1'b1;

            if (rx_ticks == MID_HI) begin
               case (rx_state)
                  RX_START: begin
                     if (rx_vote) rx_state <= RX_IDLE;
                  end
                  RX_DATA: begin
                     rx_shift <= {rx_vote, rx_shift[DATA_BITS-1:1]};
                  end
                  RX_PARITY: begin
                     rx_par_err <= (rx_vote != parity_bit(^rx_shift, PARITY));
                  end
                  RX_STOP: begin
                     rx_state                <= RX_IDLE;
                     rx_armed                <= rx_vote;
                     rx_data_q               <= rx_shift;
                     rx_valid_q              <= 1'b1;
                     rx_error_q[ERR_OVERRUN] <= rx_valid_q && !bus.rx_ready;
                     rx_error_q[ERR_PARITY]  <= rx_par_err;
                     rx_error_q[ERR_FRAMING] <= !rx_vote;
                  end
                  default: rx_state <= RX_IDLE;
               endcase
            end

            if (rx_ticks == OS_LAST) begin
               case (rx_state)
                  RX_START: rx_state <= RX_DATA;
                  RX_DATA: begin
                     if (rx_bit == DATA_LAST) begin
                        rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                     end else begin
                        rx_bit <= rx_bit + 1'b1;
                     end
                  end
                  RX_PARITY: rx_state <= RX_STOP;
                  default: ;
               endcase
            end
         end
      end
   end

   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_error = rx_error_q;

endmodule
